// File: rtl/sub_array_stream_sequencer.sv
// Captures a ROWS x COLS array and streams it one element per cycle, emitting the first SUB_ROWS
// rows column by column, then the remaining rows column by column.
module sub_array_stream_sequencer #(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned SUB_ROWS  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ROWS*COLS*BIT_WIDTH-1:0]         in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [BIT_WIDTH-1:0]                   out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_col,
  output logic                                   out_region,
  output logic                                   out_last,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam int SubEnd  = int'(SUB_ROWS) - 1;
  localparam int RestEnd = int'(ROWS) - 1;
  localparam int ColEnd  = int'(COLS) - 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSub  = 2'd1;
  localparam logic [1:0] StRest = 2'd2;

  if (SUB_ROWS > ROWS || ROWS < 1 || COLS < 1) begin : g_param_check
    $error("sub_array_stream_sequencer: illegal ROWS/COLS/SUB_ROWS");
  end

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          capture;

  // Packed so that arr_q[r][c] lands on the row-major slice of in_data.
  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] arr_q;

  logic row_at_end;
  logic col_at_end;

  always_comb begin
    row_at_end = 1'b0;
    if (state_q == StSub) begin
      row_at_end = (int'(row_q) == SubEnd);
    end else if (state_q == StRest) begin
      row_at_end = (int'(row_q) == RestEnd);
    end
  end

  assign col_at_end = (int'(col_q) == ColEnd);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          capture = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = (SUB_ROWS > 0) ? StSub : StRest;
        end
      end
      StSub, StRest: begin
        if (out_ready) begin
          if (!row_at_end) begin
            row_d = row_q + 1'b1;
          end else if (!col_at_end) begin
            row_d = (state_q == StSub) ? '0 : RW'(SUB_ROWS);
            col_d = col_q + 1'b1;
          end else if (state_q == StSub && SUB_ROWS < ROWS) begin
            state_d = StRest;
            row_d   = RW'(SUB_ROWS);
            col_d   = '0;
          end else begin
            state_d = StIdle;
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      arr_q <= in_data;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StSub) || (state_q == StRest);
  assign out_data   = arr_q[row_q][col_q];
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign out_region = (state_q == StRest);
  // The final element is in REST unless the sub region covers every row.
  assign out_last   = row_at_end && col_at_end &&
                      ((state_q == StRest) || (state_q == StSub && SUB_ROWS == ROWS));

endmodule

// File: doc/sub_array_stream_sequencer.md
# sub_array_stream_sequencer

Sequences a captured ROWS x COLS array of BIT_WIDTH elements out as a stream of single elements, one per cycle, over a ready/valid handshake. Emission order is the split sub-array order used by our flattening blocks: the first SUB_ROWS rows column by column, then the remaining ROWS-SUB_ROWS rows column by column. It sits between a producer that delivers a whole array in parallel and a narrow downstream consumer such as a serial link, FIFO or MAC lane, so that consumer sees elements in the same order as the flattened vector layout.

## Interface
- BIT_WIDTH, 4, element width in bits
- ROWS, 8, array rows; must be ≥ 1
- COLS, 8, array columns; must be ≥ 1
- SUB_ROWS, 4, rows in the first region; legal range 0..ROWS
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  ROWS*COLS*BIT_WIDTH  parallel array, row-major: element [r][c] occupies bits [(r*COLS+c)*BIT_WIDTH +: BIT_WIDTH]
- in_valid  in  1  in_data is valid
- in_ready  out  1  sequencer can capture an array
- out_data  out  BIT_WIDTH  current element
- out_row  out  clog2(ROWS) (min 1)  row index of out_data
- out_col  out  clog2(COLS) (min 1)  column index of out_data
- out_region  out  1  0 = sub region (row < SUB_ROWS), 1 = remainder region
- out_last  out  1  final element of the array
- out_valid  out  1  out_* fields are valid
- out_ready  in  1  consumer accepts the element

## Operation
- FSM states: IDLE, SUB, REST.
- IDLE: in_ready=1 and out_valid=0. When in_valid&&in_ready, in_data is captured into an internal array register, row/col counters are zeroed, and the FSM moves to SUB if SUB_ROWS>0, otherwise to REST.
- SUB: emits [row][col] with row 0..SUB_ROWS-1 as the inner loop and col 0..COLS-1 as the outer loop.
- REST: same loop structure with row SUB_ROWS..ROWS-1.
- Counters advance only on an output handshake (out_valid&&out_ready).
  - Row wraps to the region start and col increments.
  - After the last element of SUB, the FSM goes to REST with row=SUB_ROWS, col=0. If SUB_ROWS==ROWS it goes to IDLE instead.
  - After the last element of REST, the FSM goes to IDLE.
- out_valid=1 in SUB and REST. in_ready=0 in both; a new array is never accepted mid-frame.
- out_data, out_row, out_col, out_region and out_last are decoded only from registered state (captured array plus counters).
- out_last=1 only on the element with linear stream index ROWS*COLS-1.
- Stream index k of element [r][c] equals its position in the flattened vector:
  - r<SUB_ROWS: k = c*SUB_ROWS + r
  - otherwise: k = COLS*SUB_ROWS + c*(ROWS-SUB_ROWS) + (r-SUB_ROWS)
- Capture register is not modified until the next IDLE handshake.
- Parameter checks: SUB_ROWS>ROWS, ROWS<1 or COLS<1 are elaboration errors.

## Timing
- Reset (rst=1 at a clock edge) takes priority over all other events.
  - Next state: IDLE, counters 0, out_valid=0, in_ready=1, out_last=0, out_region=0, out_row=0, out_col=0.
  - out_data after reset is don't-care; the bench must not check it while out_valid=0.
- Reset mid-frame aborts the frame. Remaining elements are dropped and no out_last is produced.
- Latency: input handshake at edge N → first element valid in the cycle after edge N.
- Throughput: one element per cycle while out_ready=1. A frame takes ROWS*COLS cycles, plus one IDLE cycle before the next capture.
- Backpressure: while out_valid&&!out_ready, all out_* outputs hold stable. out_valid never drops without a handshake, except on reset.
- The in_valid&&in_ready handshake and out_valid&&out_ready cannot coincide, because in_ready and out_valid are mutually exclusive.
- in_data is ignored outside the IDLE handshake cycle.

## Test plan
- ROWS=4, COLS=2, SUB_ROWS=2, BIT_WIDTH=4, element [r][c]=r*2+c, out_ready=1 → out_data sequence 0,2,1,3,4,6,5,7.
  - out_region 0,0,0,0,1,1,1,1; out_last only on value 7.
  - First out_valid one cycle after capture; in_ready returns 1 the cycle after the 8th handshake.
- Same frame with out_ready toggling 1,0,0,1,… → identical sequence with no duplicates or drops; out_* stable during every stall cycle.
- SUB_ROWS=0 → sequence 0,2,4,6,1,3,5,7, all out_region=1. SUB_ROWS=4 → same sequence, all out_region=0. Both end with out_last on 7.
- Assert rst after the 3rd handshake → next cycle out_valid=0, in_ready=1. A new frame with values +8 then streams 8,10,9,11,12,14,13,15 correctly.
- Two frames with in_valid held high continuously → second capture happens exactly one IDLE cycle after the first frame's out_last handshake. in_data changes during streaming do not affect the first frame's output.
- Default parameters (8x8, SUB_ROWS=4), random out_ready → scoreboard compares each element against the flattened-vector index formula; 64 elements with out_last on the 64th.
